// File: rtl/adc_level_accum.sv
// Reduces windows of 2^LOG2_WINDOW ADC samples to an 8-bit mean and peak.
// A snapshot request presents the most recent completed window.
module adc_level_accum #(
  parameter int unsigned SAMPLE_WIDTH = 12,
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned LOG2_WINDOW  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    snap,
  output logic                    level_valid,
  output logic [OUT_WIDTH-1:0]    level_mean,
  output logic [OUT_WIDTH-1:0]    level_peak,
  output logic                    level_fresh,
  output logic                    overrun
);

  localparam int unsigned SumWidth = SAMPLE_WIDTH + LOG2_WINDOW;

  typedef enum logic {StEmpty, StFull} state_e;

  logic                    valid_prev_q;
  logic [SumWidth-1:0]     sum_q, sum_d;
  logic [SAMPLE_WIDTH-1:0] peak_q, peak_d;
  logic [LOG2_WINDOW-1:0]  cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] win_mean_q, win_mean_d;
  logic [SAMPLE_WIDTH-1:0] win_peak_q, win_peak_d;
  state_e                  state_q, state_d;
  logic                    ovr_q, ovr_d;

  logic                    level_valid_q, level_valid_d;
  logic [OUT_WIDTH-1:0]    level_mean_q, level_mean_d;
  logic [OUT_WIDTH-1:0]    level_peak_q, level_peak_d;
  logic                    level_fresh_q, level_fresh_d;
  logic                    overrun_q, overrun_d;

  logic                    accept;
  logic                    complete;
  logic [SumWidth-1:0]     sum_inc;
  logic [SAMPLE_WIDTH-1:0] peak_max;
  logic [SAMPLE_WIDTH-1:0] mean_new;
  logic                    pending_now;
  logic                    ovr_now;

  // Held-high ready counts once: only the rising edge is a new sample.
  assign accept   = sample_valid & ~valid_prev_q;
  assign complete = accept & (cnt_q == {LOG2_WINDOW{1'b1}});
  assign sum_inc  = sum_q + SumWidth'(sample_data);
  assign peak_max = (sample_data > peak_q) ? sample_data : peak_q;
  assign mean_new = SAMPLE_WIDTH'(sum_inc >> LOG2_WINDOW);

  always_comb begin
    sum_d      = sum_q;
    peak_d     = peak_q;
    cnt_d      = cnt_q;
    win_mean_d = win_mean_q;
    win_peak_d = win_peak_q;
    if (accept) begin
      if (complete) begin
        sum_d      = '0;
        peak_d     = '0;
        cnt_d      = '0;
        win_mean_d = mean_new;
        win_peak_d = peak_max;
      end else begin
        sum_d  = sum_inc;
        peak_d = peak_max;
        cnt_d  = cnt_q + LOG2_WINDOW'(1);
      end
    end
  end

  // Completion is folded in before the snap so a coincident snap sees the new window.
  assign pending_now = (state_q == StFull) | complete;
  assign ovr_now     = ovr_q | (complete & (state_q == StFull));

  always_comb begin
    state_d       = state_q;
    ovr_d         = ovr_now;
    level_valid_d = 1'b0;
    level_mean_d  = level_mean_q;
    level_peak_d  = level_peak_q;
    level_fresh_d = level_fresh_q;
    overrun_d     = overrun_q;

    unique case (state_q)
      StEmpty: if (complete) state_d = StFull;
      StFull:  state_d = StFull;
      default: state_d = StEmpty;
    endcase

    if (snap) begin
      level_valid_d = 1'b1;
      level_fresh_d = pending_now;
      overrun_d     = ovr_now;
      if (pending_now) begin
        level_mean_d = win_mean_d[SAMPLE_WIDTH-1 -: OUT_WIDTH];
        level_peak_d = win_peak_d[SAMPLE_WIDTH-1 -: OUT_WIDTH];
      end
      state_d = StEmpty;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_prev_q  <= 1'b0;
      sum_q         <= '0;
      peak_q        <= '0;
      cnt_q         <= '0;
      win_mean_q    <= '0;
      win_peak_q    <= '0;
      state_q       <= StEmpty;
      ovr_q         <= 1'b0;
      level_valid_q <= 1'b0;
      level_mean_q  <= '0;
      level_peak_q  <= '0;
      level_fresh_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      valid_prev_q  <= sample_valid;
      sum_q         <= sum_d;
      peak_q        <= peak_d;
      cnt_q         <= cnt_d;
      win_mean_q    <= win_mean_d;
      win_peak_q    <= win_peak_d;
      state_q       <= state_d;
      ovr_q         <= ovr_d;
      level_valid_q <= level_valid_d;
      level_mean_q  <= level_mean_d;
      level_peak_q  <= level_peak_d;
      level_fresh_q <= level_fresh_d;
      overrun_q     <= overrun_d;
    end
  end

  // Low-order bits of the window registers never reach the reported levels.
  if (OUT_WIDTH < SAMPLE_WIDTH) begin : g_lsb_sink
    logic unused_lsbs;
    assign unused_lsbs = ^{win_mean_d[SAMPLE_WIDTH-OUT_WIDTH-1:0],
                           win_peak_d[SAMPLE_WIDTH-OUT_WIDTH-1:0]};
  end

  assign level_valid = level_valid_q;
  assign level_mean  = level_mean_q;
  assign level_peak  = level_peak_q;
  assign level_fresh = level_fresh_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_level_accum.sv
// Bench for adc_level_accum: queue-based window model checked every cycle,
// plus literal expectations after each snapshot.
module tb_adc_level_accum;
  localparam int SW  = 12;
  localparam int OW  = 8;
  localparam int LW  = 4;
  localparam int WIN = 1 << LW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          snap = 1'b0;
  logic          level_valid;
  logic [OW-1:0] level_mean;
  logic [OW-1:0] level_peak;
  logic          level_fresh;
  logic          overrun;

  always #5 clk = ~clk;

  adc_level_accum #(
    .SAMPLE_WIDTH(SW),
    .OUT_WIDTH   (OW),
    .LOG2_WINDOW (LW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .snap        (snap),
    .level_valid (level_valid),
    .level_mean  (level_mean),
    .level_peak  (level_peak),
    .level_fresh (level_fresh),
    .overrun     (overrun)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: samples of the open window, the last completed window, and reported levels.
  int win_samples[$];
  bit m_prev = 0, m_pending = 0, m_ovr = 0;
  int m_win_mean = 0, m_win_peak = 0;
  int e_valid = 0, e_mean = 0, e_peak = 0, e_fresh = 0, e_ovr = 0;

  task automatic model_step();
    bit acc;
    int sum, mx;
    if (reset) begin
      win_samples.delete();
      m_prev = 0; m_pending = 0; m_ovr = 0;
      m_win_mean = 0; m_win_peak = 0;
      e_valid = 0; e_mean = 0; e_peak = 0; e_fresh = 0; e_ovr = 0;
      return;
    end
    acc = sample_valid && !m_prev;
    m_prev = sample_valid;
    e_valid = int'(snap);
    if (acc) begin
      win_samples.push_back(int'(sample_data));
      if (win_samples.size() == WIN) begin
        sum = 0;
        mx = 0;
        foreach (win_samples[i]) begin
          sum += win_samples[i];
          if (win_samples[i] > mx) mx = win_samples[i];
        end
        m_win_mean = sum / WIN;
        m_win_peak = mx;
        if (m_pending) m_ovr = 1;
        m_pending = 1;
        win_samples.delete();
      end
    end
    if (snap) begin
      e_fresh = int'(m_pending);
      e_ovr = int'(m_ovr);
      if (m_pending) begin
        e_mean = m_win_mean >> (SW - OW);
        e_peak = m_win_peak >> (SW - OW);
      end
      m_pending = 0;
      m_ovr = 0;
    end
  endtask

  always begin
    @(posedge clk);
    model_step();
    #1;
    chk("cyc level_valid", 32'(level_valid), e_valid);
    chk("cyc level_mean", 32'(level_mean), e_mean);
    chk("cyc level_peak", 32'(level_peak), e_peak);
    chk("cyc level_fresh", 32'(level_fresh), e_fresh);
    chk("cyc overrun", 32'(overrun), e_ovr);
  end

  task automatic send(input logic [SW-1:0] d, input bit with_snap);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data = d;
    snap = with_snap;
    @(negedge clk);
    sample_valid = 1'b0;
    snap = 1'b0;
  endtask

  task automatic send_n(input logic [SW-1:0] d, input int n);
    for (int i = 0; i < n; i++) send(d, 1'b0);
  endtask

  task automatic do_snap();
    @(negedge clk);
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
  endtask

  // Called at the negedge right after the snap was registered.
  task automatic expect_lit(input string tag, input int vld, input int mean, input int peak,
                            input int fresh, input int ovr);
    chk({tag, " valid"}, 32'(level_valid), vld);
    chk({tag, " mean"}, 32'(level_mean), mean);
    chk({tag, " peak"}, 32'(level_peak), peak);
    chk({tag, " fresh"}, 32'(level_fresh), fresh);
    chk({tag, " overrun"}, 32'(overrun), ovr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    expect_lit("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    send_n(12'h800, 16);
    do_snap();
    expect_lit("const", 1, 8'h80, 8'h80, 1, 0);

    for (int i = 0; i < 16; i++) send(12'(i * 256), 1'b0);
    do_snap();
    expect_lit("ramp", 1, 8'h78, 8'hF0, 1, 0);

    @(negedge clk);
    sample_valid = 1'b1;
    sample_data = 12'hFFF;
    repeat (49) @(negedge clk);
    sample_valid = 1'b0;
    send_n(12'h000, 15);
    do_snap();
    expect_lit("held", 1, 8'h0F, 8'hFF, 1, 0);

    do_snap();
    expect_lit("stale", 1, 8'h0F, 8'hFF, 0, 0);

    send_n(12'h400, 16);
    send_n(12'hC00, 16);
    do_snap();
    expect_lit("overrun", 1, 8'hC0, 8'hC0, 1, 1);
    do_snap();
    expect_lit("after ovr", 1, 8'hC0, 8'hC0, 0, 0);

    send_n(12'h300, 15);
    send(12'h300, 1'b1);
    expect_lit("coincide", 1, 8'h30, 8'h30, 1, 0);
    do_snap();
    expect_lit("coincide next", 1, 8'h30, 8'h30, 0, 0);

    send_n(12'hFFF, 8);
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_lit("in reset", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    expect_lit("in reset late", 0, 0, 0, 0, 0);
    reset = 1'b0;
    send_n(12'h100, 16);
    do_snap();
    expect_lit("mid-window reset", 1, 8'h10, 8'h10, 1, 0);

    // Ready high across reset release counts as an edge on the first clock.
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b1;
    sample_data = 12'h200;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sample_valid = 1'b0;
    send_n(12'h200, 15);
    do_snap();
    expect_lit("valid at release", 1, 8'h20, 8'h20, 1, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
